// File: rtl/capi_mmio_pkg.sv
// Shared definitions for the host-side AFU MMIO initiator: bus widths,
// FSM state encoding and the MMIO parity helper.
package capi_mmio_pkg;

    localparam int MMIO_AW = 24;
    localparam int MMIO_DW = 64;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        PARCHK,
        RESP
    } mmio_state_e;

    // Narrower fields are zero-extended by the caller; that leaves the XOR unchanged.
    function automatic logic mmio_par(input logic [MMIO_DW-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/mmio_host_master.sv
// Host-side MMIO initiator: takes one local command at a time, issues it as a
// single ha_mmval pulse, waits for ah_mmack with a timeout and reports the result.
//
// Request port handshake: a command transfers on a rising edge where
// req_valid & req_ready are both 1; req_ready stays 0 until the rsp_valid
// cycle has passed, and rsp_valid is a one-cycle pulse with no back-pressure.
module mmio_host_master
    import capi_mmio_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int PAR_LAG        = 1,
    parameter int PAR_ODD        = 0
) (
    input  logic               ha_pclock,
    input  logic               ha_preset_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_cfg,
    input  logic               req_rnw,
    input  logic               req_dw,
    input  logic [0:MMIO_AW-1] req_addr,
    input  logic [0:MMIO_DW-1] req_wdata,
    output logic               rsp_valid,
    output logic [0:MMIO_DW-1] rsp_rdata,
    output logic               rsp_timeout,
    output logic               rsp_parerr,
    output logic               stray_ack,
    output logic               ha_mmval,
    output logic               ha_mmcfg,
    output logic               ha_mmrnw,
    output logic               ha_mmdw,
    output logic [0:MMIO_AW-1] ha_mmad,
    output logic               ha_mmadpar,
    output logic [0:MMIO_DW-1] ha_mmdata,
    output logic               ha_mmdatapar,
    input  logic               ah_mmack,
    input  logic [0:MMIO_DW-1] ah_mmdata,
    input  logic               ah_mmdatapar
);

    localparam logic L_ODD = (PAR_ODD != 0);

    mmio_state_e        r_state;
    mmio_state_e        w_next;
    logic               r_ready;
    logic               r_cfg;
    logic               r_rnw;
    logic               r_dw;
    logic [0:MMIO_AW-1] r_addr;
    logic [0:MMIO_DW-1] r_wdata;
    logic [0:MMIO_DW-1] r_data;
    logic [15:0]        r_cnt;
    logic               r_timeout;
    logic               r_parerr;
    logic               r_stray;

    logic [16:0]        w_cnt_inc;
    logic               w_to_hit;
    logic               w_issue;
    logic               w_resp;
    logic [0:MMIO_DW-1] w_wr_data;
    logic [0:31]        w_half;
    logic [0:MMIO_DW-1] w_fmt;

    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_to_hit  = (w_cnt_inc == 17'(TIMEOUT_CYCLES));

    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // An ack takes priority over a timeout landing in the same cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (req_valid && r_ready) w_next = ISSUE;
            ISSUE:    w_next = WAIT_ACK;
            WAIT_ACK: begin
                if (ah_mmack) begin
                    w_next = (r_rnw && (PAR_LAG != 0)) ? PARCHK : RESP;
                end else if (w_to_hit) begin
                    w_next = RESP;
                end
            end
            PARCHK:   w_next = RESP;
            RESP:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge ha_pclock or negedge ha_preset_n) begin
        if (!ha_preset_n) begin
            r_ready   <= 1'b0;
            r_cfg     <= 1'b0;
            r_rnw     <= 1'b0;
            r_dw      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_data    <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
            r_parerr  <= 1'b0;
            r_stray   <= 1'b0;
        end else begin
            r_ready <= (w_next == IDLE);
            r_stray <= ah_mmack && (r_state != WAIT_ACK);
            case (r_state)
                IDLE: begin
                    if (req_valid && r_ready) begin
                        r_cfg     <= req_cfg;
                        r_rnw     <= req_rnw;
                        r_dw      <= req_dw;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_cnt     <= '0;
                        r_timeout <= 1'b0;
                        r_parerr  <= 1'b0;
                    end
                end
                WAIT_ACK: begin
                    if (ah_mmack) begin
                        r_data <= ah_mmdata;
                        r_cnt  <= '0;
                        if (r_rnw && (PAR_LAG == 0)) begin
                            r_parerr <= (ah_mmdatapar != mmio_par(ah_mmdata, L_ODD));
                        end
                    end else if (w_to_hit) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc[15:0];
                    end
                end
                PARCHK: r_parerr <= (ah_mmdatapar != mmio_par(r_data, L_ODD));
                default: ;
            endcase
        end
    end

    assign w_issue   = (r_state == ISSUE);
    assign w_resp    = (r_state == RESP);
    assign w_wr_data = r_dw ? r_wdata : {r_wdata[32:63], r_wdata[32:63]};
    assign w_half    = r_addr[23] ? r_data[32:63] : r_data[0:31];
    assign w_fmt     = r_dw ? r_data : {32'h0, w_half};

    assign req_ready    = r_ready;
    assign stray_ack    = r_stray;
    assign ha_mmval     = w_issue;
    assign ha_mmcfg     = w_issue & r_cfg;
    assign ha_mmrnw     = w_issue & r_rnw;
    assign ha_mmdw      = w_issue & r_dw;
    assign ha_mmad      = w_issue ? r_addr : '0;
    assign ha_mmadpar   = w_issue & mmio_par({40'h0, r_addr}, L_ODD);
    assign ha_mmdata    = w_issue ? w_wr_data : '0;
    assign ha_mmdatapar = w_issue & mmio_par(w_wr_data, L_ODD);

    assign rsp_valid   = w_resp;
    assign rsp_rdata   = (w_resp && r_rnw && !r_timeout) ? w_fmt : '0;
    assign rsp_timeout = w_resp & r_timeout;
    assign rsp_parerr  = w_resp & r_parerr & ~r_timeout;

endmodule

// File: tb/tb_mmio_host_master.sv
// Bench for mmio_host_master: two instances (parity lag 1 / even, lag 0 / odd)
// share one request stream and one responder; results are checked against a cycle-count model.
module tb_mmio_host_master;

    localparam int TO = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_cfg   = 1'b0;
    logic        req_rnw   = 1'b0;
    logic        req_dw    = 1'b0;
    logic [0:23] req_addr  = '0;
    logic [0:63] req_wdata = '0;
    logic        ah_mmack  = 1'b0;
    logic [0:63] ah_mmdata = '0;
    logic        ah_par [2];

    logic        ready     [2];
    logic        rsp_valid [2];
    logic [0:63] rsp_rdata [2];
    logic        rsp_to    [2];
    logic        rsp_pe    [2];
    logic        stray     [2];
    logic        mmval     [2];
    logic        mmcfg     [2];
    logic        mmrnw     [2];
    logic        mmdw      [2];
    logic [0:23] mmad      [2];
    logic        mmadpar   [2];
    logic [0:63] mmdata    [2];
    logic        mmdatapar [2];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mmio_host_master #(.TIMEOUT_CYCLES(TO), .PAR_LAG(1), .PAR_ODD(0)) u_dut_lag1 (
        .ha_pclock(clk), .ha_preset_n(rst_n),
        .req_valid(req_valid), .req_ready(ready[0]), .req_cfg(req_cfg), .req_rnw(req_rnw),
        .req_dw(req_dw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_timeout(rsp_to[0]),
        .rsp_parerr(rsp_pe[0]), .stray_ack(stray[0]),
        .ha_mmval(mmval[0]), .ha_mmcfg(mmcfg[0]), .ha_mmrnw(mmrnw[0]), .ha_mmdw(mmdw[0]),
        .ha_mmad(mmad[0]), .ha_mmadpar(mmadpar[0]), .ha_mmdata(mmdata[0]),
        .ha_mmdatapar(mmdatapar[0]),
        .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata), .ah_mmdatapar(ah_par[0])
    );

    mmio_host_master #(.TIMEOUT_CYCLES(TO), .PAR_LAG(0), .PAR_ODD(1)) u_dut_lag0 (
        .ha_pclock(clk), .ha_preset_n(rst_n),
        .req_valid(req_valid), .req_ready(ready[1]), .req_cfg(req_cfg), .req_rnw(req_rnw),
        .req_dw(req_dw), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_timeout(rsp_to[1]),
        .rsp_parerr(rsp_pe[1]), .stray_ack(stray[1]),
        .ha_mmval(mmval[1]), .ha_mmcfg(mmcfg[1]), .ha_mmrnw(mmrnw[1]), .ha_mmdw(mmdw[1]),
        .ha_mmad(mmad[1]), .ha_mmadpar(mmadpar[1]), .ha_mmdata(mmdata[1]),
        .ha_mmdatapar(mmdatapar[1]),
        .ah_mmack(ah_mmack), .ah_mmdata(ah_mmdata), .ah_mmdatapar(ah_par[1])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    function automatic logic any_out(input int d);
        return ready[d] | rsp_valid[d] | (|rsp_rdata[d]) | rsp_to[d] | rsp_pe[d] | stray[d] |
               mmval[d] | mmcfg[d] | mmrnw[d] | mmdw[d] | (|mmad[d]) | mmadpar[d] |
               (|mmdata[d]) | mmdatapar[d];
    endfunction

    // One command; the responder acks for len cycles starting dly cycles after ha_mmval.
    task automatic run_txn(input string name, input logic cfg, input logic rnw, input logic dw,
                           input logic [0:23] addr, input logic [0:63] wdata,
                           input logic [0:63] rdat, input bit ack_en, input int dly,
                           input int len, input bit bad0, input bit bad1);
        int          a, lim, exp_stray;
        bit          acked;
        logic [0:63] exp_rd, exp_md;
        int          exp_r [2];
        int          n_mmval [2], mm_k [2], n_rsp [2], rsp_k [2], n_stray [2];
        int          bad_idle [2], bad_rdy [2];
        logic [0:23] cap_ad [2];
        logic [0:63] cap_md [2], cap_rd [2];
        logic        cap_cfg [2], cap_rnw [2], cap_dw [2], cap_adp [2], cap_dp [2];
        logic        cap_to [2], cap_pe [2];
        bit          bad [2];
        logic        ack_now;

        a        = 1 + dly;
        acked    = ack_en && (dly >= 1) && (dly <= TO);
        exp_r[0] = acked ? a + 1 + (rnw ? 1 : 0) : TO + 2;
        exp_r[1] = acked ? a + 1 : TO + 2;
        lim      = (((a + len) > (TO + 2)) ? (a + len) : (TO + 2)) + 4;
        exp_stray = ack_en ? (acked ? len - 1 : len) : 0;
        exp_md   = dw ? wdata : {wdata[32:63], wdata[32:63]};
        if (acked && rnw) begin
            if (dw)             exp_rd = rdat;
            else if (addr[23])  exp_rd = {32'h0, rdat[32:63]};
            else                exp_rd = {32'h0, rdat[0:31]};
        end else begin
            exp_rd = '0;
        end
        bad[0] = bad0;
        bad[1] = bad1;
        for (int d = 0; d < 2; d++) begin
            n_mmval[d] = 0; mm_k[d] = -1; n_rsp[d] = 0; rsp_k[d] = -1; n_stray[d] = 0;
            bad_idle[d] = 0; bad_rdy[d] = 0;
            cap_ad[d] = 'x; cap_md[d] = 'x; cap_rd[d] = 'x; cap_cfg[d] = 1'bx;
            cap_rnw[d] = 1'bx; cap_dw[d] = 1'bx; cap_adp[d] = 1'bx; cap_dp[d] = 1'bx;
            cap_to[d] = 1'bx; cap_pe[d] = 1'bx;
        end

        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("%s_ready_pre_%0d", name, d), ready[d], 1);
        req_valid = 1'b1; req_cfg = cfg; req_rnw = rnw; req_dw = dw;
        req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        for (int k = 1; k <= lim; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mmval[d]) begin
                    n_mmval[d]++; mm_k[d] = k;
                    cap_cfg[d] = mmcfg[d]; cap_rnw[d] = mmrnw[d]; cap_dw[d] = mmdw[d];
                    cap_ad[d] = mmad[d]; cap_adp[d] = mmadpar[d];
                    cap_md[d] = mmdata[d]; cap_dp[d] = mmdatapar[d];
                end else if (mmcfg[d] | mmrnw[d] | mmdw[d] | (|mmad[d]) | mmadpar[d] |
                             (|mmdata[d]) | mmdatapar[d]) begin
                    bad_idle[d]++;
                end
                if (rsp_valid[d]) begin
                    n_rsp[d]++; rsp_k[d] = k;
                    cap_rd[d] = rsp_rdata[d]; cap_to[d] = rsp_to[d]; cap_pe[d] = rsp_pe[d];
                end else if ((|rsp_rdata[d]) | rsp_to[d] | rsp_pe[d]) begin
                    bad_idle[d]++;
                end
                if (stray[d]) n_stray[d]++;
                if (ready[d] !== (k > exp_r[d])) bad_rdy[d]++;
            end
            ack_now   = ack_en && (k >= a) && (k < a + len);
            ah_mmack  = ack_now;
            ah_mmdata = ack_now ? rdat : {$urandom, $urandom};
            ah_par[0] = (ack_en && k == a + 1) ? ((^rdat) ^ bad[0]) : 1'($urandom_range(0, 1));
            ah_par[1] = (ack_en && k == a) ? (~(^rdat) ^ bad[1]) : 1'($urandom_range(0, 1));
        end
        ah_mmack = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_mmval_cnt_%0d", name, d), n_mmval[d], 1);
            chk($sformatf("%s_mmval_cyc_%0d", name, d), mm_k[d], 1);
            chk($sformatf("%s_mmcfg_%0d", name, d), cap_cfg[d], cfg);
            chk($sformatf("%s_mmrnw_%0d", name, d), cap_rnw[d], rnw);
            chk($sformatf("%s_mmdw_%0d", name, d), cap_dw[d], dw);
            chk($sformatf("%s_mmad_%0d", name, d), cap_ad[d], addr);
            chk($sformatf("%s_mmadpar_%0d", name, d), cap_adp[d], (^addr) ^ (d == 1));
            chk($sformatf("%s_mmdata_%0d", name, d), cap_md[d], exp_md);
            chk($sformatf("%s_mmdatapar_%0d", name, d), cap_dp[d], (^exp_md) ^ (d == 1));
            chk($sformatf("%s_idle_zero_%0d", name, d), bad_idle[d], 0);
            chk($sformatf("%s_rsp_cnt_%0d", name, d), n_rsp[d], 1);
            chk($sformatf("%s_rsp_cyc_%0d", name, d), rsp_k[d], exp_r[d]);
            chk($sformatf("%s_rdata_%0d", name, d), cap_rd[d], exp_rd);
            chk($sformatf("%s_timeout_%0d", name, d), cap_to[d], !acked);
            chk($sformatf("%s_parerr_%0d", name, d), cap_pe[d], acked && rnw && bad[d]);
            chk($sformatf("%s_stray_%0d", name, d), n_stray[d], exp_stray);
            chk($sformatf("%s_ready_seq_%0d", name, d), bad_rdy[d], 0);
        end
    endtask

    localparam logic [0:63] DESC0 = 64'h0000_0001_0001_0010;

    initial begin
        int n_late_rsp;
        ah_par[0] = 1'b0;
        ah_par[1] = 1'b0;

        #12;
        for (int d = 0; d < 2; d++) chk($sformatf("reset_outs_%0d", d), any_out(d), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn("cfg_dw_rd",   1, 1, 1, 24'h000000, 64'h0, DESC0, 1, 1, 1, 0, 0);
        run_txn("cfg_w_rd_a1", 1, 1, 0, 24'h000001, 64'h0, DESC0, 1, 1, 1, 0, 0);
        run_txn("cfg_w_rd_a0", 1, 1, 0, 24'h000000, 64'h0, DESC0, 1, 1, 1, 0, 0);
        run_txn("wr_timeout",  0, 0, 1, 24'h00abcd, 64'h1234_5678_9abc_def0, 64'h0,
                1, TO + 4, 1, 0, 0);
        run_txn("wr_word",     0, 0, 0, 24'h000102, 64'hdead_beef_cafe_f00d, 64'h0,
                1, 2, 1, 0, 0);
        run_txn("rd_parerr",   0, 1, 1, 24'h000010, 64'h0, 64'h1, 1, 1, 1, 1, 1);
        run_txn("ack_hold2",   0, 1, 1, 24'h000020, 64'h0, 64'h5a5a_0f0f_1234_8765,
                1, 1, 2, 0, 0);
        run_txn("ack_on_to",   0, 1, 0, 24'h000021, 64'h0, 64'h0123_4567_89ab_cdef,
                1, TO, 1, 0, 0);

        // Reset pulse while both instances sit in WAIT_ACK.
        @(negedge clk);
        req_valid = 1'b1; req_cfg = 1'b0; req_rnw = 1'b0; req_dw = 1'b1;
        req_addr = 24'h000300; req_wdata = 64'hffff_0000_ffff_0000;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) chk($sformatf("midrst_outs_%0d", d), any_out(d), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) chk($sformatf("midrst_ready_%0d", d), ready[d], 1);
        n_late_rsp = 0;
        repeat (TO + 6) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) if (rsp_valid[d] || mmval[d]) n_late_rsp++;
        end
        chk("midrst_no_rsp", n_late_rsp, 0);
        run_txn("post_rst_rd", 1, 1, 1, 24'h000000, 64'h0, DESC0, 1, 1, 1, 0, 0);

        for (int i = 0; i < 12; i++) begin
            run_txn($sformatf("rnd%0d", i),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    24'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                    ($urandom_range(0, 7) != 0), int'($urandom_range(1, TO + 3)),
                    int'($urandom_range(1, 2)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mmio_host_master.md
Name: mmio_host_master

Overview:
- PSL-side initiator for the AFU MMIO interface; it drives ha_mm* requests into an AFU responder and collects ah_mmack/ah_mmdata/ah_mmdatapar.
- Accepts one command at a time from a local valid/ready request port, issues it as a single-cycle ha_mmval pulse, and waits for the acknowledge with a timeout.
- Returns read data, timeout and parity status on a response port.
- Used as the host-side driver in the AFU simulation and bring-up harness.

Parameters:
- TIMEOUT_CYCLES, 255: WAIT_ACK cycles before abandoning a request (1..65535).
- PAR_LAG, 1: cycles after ack at which ah_mmdatapar is valid for the acked data (0 or 1).
- PAR_ODD, 0: 0 means parity is the plain XOR of the bits; 1 means the inverted XOR.

Ports:
- ha_pclock  in  1  main clock; all logic on the rising edge.
- ha_preset_n  in  1  reset; asynchronous assert, active-low.
- req_valid  in  1  command present.
- req_ready  out  1  block idle; a command is accepted on req_valid & req_ready.
- req_cfg  in  1  AFU descriptor-space access.
- req_rnw  in  1  1 = read, 0 = write.
- req_dw  in  1  1 = doubleword, 0 = word.
- req_addr  in  [0:23]  MMIO word address.
- req_wdata  in  [0:63]  write data; bits [32:63] are used for word writes.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  [0:63]  read data; 0 for writes and timeouts.
- rsp_timeout  out  1  no ack was received.
- rsp_parerr  out  1  read-data parity mismatch.
- stray_ack  out  1  one-cycle pulse on an unexpected ah_mmack.
- ha_mmval  out  1  request valid.
- ha_mmcfg  out  1  descriptor-space access.
- ha_mmrnw  out  1  read/not-write.
- ha_mmdw  out  1  doubleword.
- ha_mmad  out  [0:23]  address.
- ha_mmadpar  out  1  address parity.
- ha_mmdata  out  [0:63]  write data.
- ha_mmdatapar  out  1  write data parity.
- ah_mmack  in  1  AFU ack.
- ah_mmdata  in  [0:63]  AFU read data.
- ah_mmdatapar  in  1  AFU read parity.

Behaviour:
- Reset (ha_preset_n = 0, asynchronous):
  - state goes to IDLE.
  - All outputs are 0, including req_ready.
  - The timeout counter clears and any in-flight request is dropped with no response.
- req_ready is registered. It is 1 in IDLE from the first edge after reset release, and 0 from the acceptance cycle until the rsp_valid cycle.
- States and transitions:
  - IDLE: on req_valid & req_ready, latch all req_* fields and go to ISSUE.
  - ISSUE (exactly 1 cycle):
    - Drive ha_mmval=1, with ha_mmcfg/rnw/dw/ad from the latched fields.
    - ha_mmadpar = parity(ha_mmad).
    - Doubleword: ha_mmdata = wdata. Word: ha_mmdata = {wdata[32:63], wdata[32:63]}.
    - ha_mmdatapar = parity(ha_mmdata).
    - ah_mmack is ignored in this cycle.
    - Go to WAIT_ACK.
  - WAIT_ACK: the counter increments every cycle.
    - On ah_mmack=1, capture ah_mmdata into the read register and clear the counter.
      - Read with PAR_LAG=0: compare ah_mmdatapar in the same cycle, then go to RESP.
      - Read with PAR_LAG=1: go to PARCHK.
      - Write: go to RESP; no parity check.
    - If the counter reaches TIMEOUT_CYCLES with no ack, go to RESP with the timeout flag set.
  - PARCHK (1 cycle): parerr = (ah_mmdatapar != parity(captured data)); go to RESP.
  - RESP (1 cycle): assert rsp_valid with rdata, timeout and parerr; go to IDLE.
- ha_mm* outputs are 0 in every state except ISSUE.
- Read data formatting:
  - Doubleword read: rsp_rdata = captured data.
  - Word read: rsp_rdata = {32'h0, half}, where half = data[0:31] if addr[23]=0, else data[32:63].
- Response field rules:
  - On a write or a timeout, rsp_rdata = 0.
  - On a timeout, rsp_parerr = 0.
  - rsp_rdata, rsp_timeout and rsp_parerr are 0 whenever rsp_valid = 0.
- Latency with a responder that acks one cycle after ha_mmval:
  - Accept at T, ha_mmval at T+1, ack at T+2.
  - PAR_LAG=1: rsp_valid at T+4. PAR_LAG=0: rsp_valid at T+3.
- stray_ack pulses the cycle after ah_mmack=1 is seen in IDLE, ISSUE, PARCHK or RESP. This covers late acks after a timeout and repeated acks. A stray ack never changes state or data.
- If ack arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins.
- Back-to-back commands: the next request is acceptable the cycle after rsp_valid, so ISSUE pulses are separated by at least 3 cycles.

Decomposition:
- Package capi_mmio_pkg holds:
  - MMIO_AW=24 and MMIO_DW=64.
  - State enum {IDLE, ISSUE, WAIT_ACK, PARCHK, RESP}.
  - Function mmio_par(data, odd) returning XOR reduction, inverted when odd=1.
- Sub-module: none. The counter and FSM stay in one module.

Test Plan:
- cfg doubleword read addr 0x000000 against the AFU descriptor responder -> ha_mmval for 1 cycle, ha_mmadpar=0; rsp_valid at T+4 with rsp_rdata=0x0000000100010010, rsp_parerr=0, rsp_timeout=0.
- cfg word read addr 0x000001 (responder returns 0x0000000100010010) -> rsp_rdata=0x0000000000010010; word read addr 0x000000 -> 0x0000000000000001.
- Non-cfg write, TIMEOUT_CYCLES=16, responder never acks -> ha_mmdata=wdata for exactly 1 cycle; rsp_valid with rsp_timeout=1 and rdata=0 after 16 WAIT_ACK cycles; a late ack 3 cycles later -> one stray_ack pulse and no second rsp_valid.
- Read of 0x0000000000000001 with ah_mmdatapar forced to 0 on the parity cycle -> rsp_parerr=1 with rsp_rdata still 0x0000000000000001; with PAR_LAG=0 the check uses the ack-cycle parity.
- ha_preset_n pulled low for 1 cycle during WAIT_ACK -> all outputs 0 immediately; no rsp_valid; req_ready=1 on the first edge after release; a new read completes normally.
- Ack held high for 2 cycles, and the ack arriving exactly on the timeout cycle -> the ack wins (rsp_timeout=0); the extra ack cycle yields one stray_ack pulse.
